// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit engine
// Contents: FSM state enum, controlReg bit indices, word-length encoding,
// oversampling constant and a word-length helper.
// Config macro: UART_TX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

  localparam int TICKS_PER_BIT = 16;

  localparam int CTRL_WLEN_LO = 0;
  localparam int CTRL_WLEN_HI = 1;
  localparam int CTRL_STOP2   = 2;
  localparam int CTRL_PAR_EN  = 3;
  localparam int CTRL_EVEN    = 4;
  localparam int CTRL_STICK   = 5;
  localparam int CTRL_BREAK   = 6;

  typedef enum logic [1:0] {
    WLEN_5 = 2'd0,
    WLEN_6 = 2'd1,
    WLEN_7 = 2'd2,
    WLEN_8 = 2'd3
  } wlen_t;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_STOP
  } tx_state_t;
`endif

  // Number of data bits carried by a frame for a given word-length code.
  function automatic logic [3:0] data_bits(input wlen_t wlen);
    return 4'd5 + {2'b00, wlen};
  endfunction

endpackage

// File: rtl/uart_tx_parity_gen.sv
// rtl/uart_tx_parity_gen.sv - combinational parity bit generator
// Ports: data (frame byte), word_len (5..8 bit code), even (even-parity
// select), stick (stick parity) -> parity (bit to transmit).
// Config macro: UART_TX_PARITY_EN; the module exists only when it is defined.
`ifdef UART_TX_PARITY_EN
module uart_tx_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  wlen_t      word_len,
  input  logic       even,
  input  logic       stick,
  output logic       parity
);

  logic [7:0] mask;
  logic       data_xor;

  always_comb begin
    // Bits above the word length never reach the line, so they must not
    // contribute to parity either.
    mask     = 8'hFF >> (4'd8 - data_bits(word_len));
    data_xor = ^(data & mask);
    if (stick) begin
      parity = ~even;
    end else begin
      parity = even ? data_xor : ~data_xor;
    end
  end

endmodule
`endif

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 16x-oversampled UART transmit framer
// Ports: clock, resetN (sync, active-low), baudRateX16Tick (16x baud strobe),
// controlReg (line control), fifoEmpty/fifoData (FWFT TX FIFO head) ->
// fifoRe (pop strobe), uartTxLine (registered serial out), txBusy, txEmpty.
// Config macro: UART_TX_PARITY_EN compiles in the parity bit.
module uart_tx_engine (
  input  logic       clock,
  input  logic       resetN,
  input  logic       baudRateX16Tick,
  input  logic [6:0] controlReg,
  input  logic       fifoEmpty,
  input  logic [7:0] fifoData,
  output logic       fifoRe,
  output logic       uartTxLine,
  output logic       txBusy,
  output logic       txEmpty
);
  import uart_pkg::*;

  tx_state_t  state, state_next;
  logic [3:0] tick_cnt, tick_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  wlen_t      wlen;
  logic       stop2;
  logic       line_next;
  logic       bit_end;
  logic       brk;

  assign brk     = controlReg[CTRL_BREAK];
  assign bit_end = baudRateX16Tick && (tick_cnt == 4'(TICKS_PER_BIT - 1));

`ifdef UART_TX_PARITY_EN
  logic par_en, par_bit, par_calc;

  // Parity is computed from the FIFO head during LOAD and latched with the
  // byte, so the shift register can be destroyed while shifting.
  uart_tx_parity_gen u_parity (
    .data     (fifoData),
    .word_len (wlen_t'(controlReg[CTRL_WLEN_HI:CTRL_WLEN_LO])),
    .even     (controlReg[CTRL_EVEN]),
    .stick    (controlReg[CTRL_STICK]),
    .parity   (par_calc)
  );
`else
  logic unused_ctrl;
  assign unused_ctrl = ^controlReg[CTRL_STICK:CTRL_PAR_EN];
`endif

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      wlen       <= WLEN_5;
      stop2      <= 1'b0;
      uartTxLine <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      uartTxLine <= line_next;
      if (state == ST_LOAD) begin
        wlen  <= wlen_t'(controlReg[CTRL_WLEN_HI:CTRL_WLEN_LO]);
        stop2 <= controlReg[CTRL_STOP2];
`ifdef UART_TX_PARITY_EN
        par_en  <= controlReg[CTRL_PAR_EN];
        par_bit <= par_calc;
`endif
      end
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    line_next     = 1'b1;

    // IDLE and LOAD never count, so a tick in LOAD is dropped; the counter
    // wraps to 0 on every bit end, so each bit state starts from zero.
    if (baudRateX16Tick && state != ST_IDLE && state != ST_LOAD) begin
      tick_cnt_next = tick_cnt + 4'd1;
    end

    case (state)
      ST_IDLE: begin
        if (!fifoEmpty && !brk) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        shift_next = fifoData;
        state_next = ST_START;
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'(data_bits(wlen) - 4'd1)) begin
            bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = par_en ? ST_PARITY : ST_STOP;
`else
            state_next   = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        // bit_cnt counts completed stop bits; two-stop frames run it to 1.
        if (bit_end) begin
          if (bit_cnt == {2'b00, stop2}) begin
            bit_cnt_next = 3'd0;
            state_next   = ST_IDLE;
          end else begin
            bit_cnt_next = 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line register is loaded from the next state so that the level
    // appears on the very first cycle of each state.
    case (state_next)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_next = par_bit;
`endif
      default:   line_next = 1'b1;
    endcase
    if (brk) line_next = 1'b0;
  end

  // Gated by resetN so a frame aborted in LOAD never pops the FIFO.
  assign fifoRe  = (state == ST_LOAD) && resetN;
  assign txBusy  = (state != ST_IDLE);
  assign txEmpty = !txBusy && fifoEmpty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

  logic       clock = 1'b0;
  logic       resetN;
  logic       baudRateX16Tick;
  logic [6:0] controlReg;
  logic       fifoEmpty;
  logic [7:0] fifoData;
  logic       fifoRe;
  logic       uartTxLine;
  logic       txBusy;
  logic       txEmpty;

  always #5 clock = ~clock;

  uart_tx_engine dut (
    .clock           (clock),
    .resetN          (resetN),
    .baudRateX16Tick (baudRateX16Tick),
    .controlReg      (controlReg),
    .fifoEmpty       (fifoEmpty),
    .fifoData        (fifoData),
    .fifoRe          (fifoRe),
    .uartTxLine      (uartTxLine),
    .txBusy          (txBusy),
    .txEmpty         (txEmpty)
  );

  typedef struct {
    int         idx;
    logic [6:0] ctrl;
    logic       rstn;
  } event_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         re_count = 0;
  logic [7:0] fifo_q[$];
  logic [3:0] exp_q[$];   // per cycle {line, busy, fifoRe, txEmpty}
  event_t     ev_q[$];

  task automatic check(input string tag, input int idx, input logic [3:0] obs, input logic [3:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed line/busy/re/empty=%b expected %b", tag, idx, obs, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifoEmpty = 1'b0;
    fifoData  = fifo_q[0];
  endtask

  // Sample at the falling edge, then let the FIFO pop after the rising edge.
  task automatic run_cycle(output logic [3:0] obs);
    logic do_pop;
    @(negedge clock);
    obs    = {uartTxLine, txBusy, fifoRe, txEmpty};
    do_pop = fifoRe;
    if (fifoRe) re_count++;
    @(posedge clock);
    #1;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifoEmpty = (fifo_q.size() == 0);
    fifoData  = fifoEmpty ? 8'h00 : fifo_q[0];
  endtask

  // Reference frame: one IDLE cycle, one LOAD cycle, then 16-cycle levels.
  task automatic model_frame(input logic [7:0] d, input logic [6:0] c, input bit with_idle);
    int   n;
    int   ones;
    bit   pe;
    logic par;
    n = 5 + int'(c[1:0]);
`ifdef UART_TX_PARITY_EN
    pe = c[3];
`else
    pe = 1'b0;
`endif
    if (with_idle) exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1110);
    repeat (16) exp_q.push_back(4'b0100);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(d[i]);
      repeat (16) exp_q.push_back({d[i], 3'b100});
    end
    if (pe) begin
      if (c[5])      par = ~c[4];
      else if (c[4]) par = logic'(ones % 2);
      else           par = logic'((ones + 1) % 2);
      repeat (16) exp_q.push_back({par, 3'b100});
    end
    repeat (c[2] ? 32 : 16) exp_q.push_back(4'b1100);
  endtask

  task automatic tail(input int k);
    repeat (k) exp_q.push_back(4'b1001);
  endtask

  task automatic add_event(input int idx, input logic [6:0] ctrl, input logic rstn);
    event_t e;
    e.idx  = idx;
    e.ctrl = ctrl;
    e.rstn = rstn;
    ev_q.push_back(e);
  endtask

  task automatic run_stream(input string tag, input int frames);
    logic [3:0] obs;
    int         n;
    n        = exp_q.size();
    re_count = 0;
    for (int i = 0; i < n; i++) begin
      run_cycle(obs);
      check(tag, i, obs, exp_q[i]);
      while (ev_q.size() > 0 && ev_q[0].idx == i) begin
        controlReg = ev_q[0].ctrl;
        resetN     = ev_q[0].rstn;
        void'(ev_q.pop_front());
      end
    end
    vectors++;
    assert (re_count === frames) else begin
      miscompares++;
      $error("FAIL %s_fifoRe_pulses: observed %0d expected %0d", tag, re_count, frames);
    end
    exp_q.delete();
    ev_q.delete();
  endtask

  initial begin
    logic [3:0] obs;
    logic [7:0] d [3];
    logic [6:0] c [3];
    int         nb;
    int         start;

    resetN          = 1'b0;
    baudRateX16Tick = 1'b1;
    controlReg      = 7'h03;
    fifoEmpty       = 1'b1;
    fifoData        = 8'h00;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, with an empty and then a non-empty FIFO.
    for (int i = 0; i < 2; i++) begin
      run_cycle(obs);
      check("reset_empty", i, obs, 4'b1001);
    end
    push_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      run_cycle(obs);
      check("reset_pending", i, obs, 4'b1000);
    end
    resetN = 1'b1;

    // 8N1 0x55
    model_frame(8'h55, 7'h03, 1'b1);
    tail(4);
    run_stream("8N1_55", 1);

    // 7E1 0x41
    controlReg = 7'b0011010;
    push_byte(8'h41);
    model_frame(8'h41, 7'b0011010, 1'b1);
    tail(4);
    run_stream("7E1_41", 1);

    // 5 bits, odd parity, 2 stop, 0x1F
    controlReg = 7'b0001100;
    push_byte(8'h1F);
    model_frame(8'h1F, 7'b0001100, 1'b1);
    tail(4);
    run_stream("5O2_1F", 1);

    // Two bytes back to back, 8N1
    controlReg = 7'h03;
    push_byte(8'hA7);
    push_byte(8'h3C);
    model_frame(8'hA7, 7'h03, 1'b1);
    model_frame(8'h3C, 7'h03, 1'b1);
    tail(4);
    run_stream("b2b_8N1", 2);

    // Break raised mid-DATA of frame 1, held past its end, then released.
    controlReg = 7'h03;
    push_byte(8'hA5);
    push_byte(8'h3C);
    model_frame(8'hA5, 7'h03, 1'b1);
    for (int k = 62; k < exp_q.size(); k++) exp_q[k] = exp_q[k] & 4'b0111;
    repeat (30) exp_q.push_back(4'b0000);
    model_frame(8'h3C, 7'h03, 1'b0);
    tail(4);
    add_event(60, 7'h43, 1'b1);
    add_event(190, 7'h03, 1'b1);
    run_stream("break", 2);

    // Reset pulse mid-DATA aborts frame 1; frame 2 then runs normally.
    controlReg = 7'h03;
    push_byte(8'hC3);
    push_byte(8'h5A);
    model_frame(8'hC3, 7'h03, 1'b1);
    while (exp_q.size() > 72) void'(exp_q.pop_back());
    repeat (5) exp_q.push_back(4'b1000);
    model_frame(8'h5A, 7'h03, 1'b1);
    tail(4);
    add_event(70, 7'h03, 1'b0);
    add_event(76, 7'h03, 1'b1);
    run_stream("reset_mid", 2);

    // Random bytes and line settings; controlReg changes mid-frame.
    for (int it = 0; it < 5; it++) begin
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < 3; k++) begin
        d[k] = 8'($urandom);
        c[k] = 7'($urandom_range(0, 63));
      end
      controlReg = c[0];
      for (int k = 0; k < nb; k++) push_byte(d[k]);
      for (int k = 0; k < nb; k++) begin
        start = exp_q.size();
        model_frame(d[k], c[k], 1'b1);
        add_event(start + 20, (k + 1 < nb) ? c[k + 1] : 7'($urandom_range(0, 63)), 1'b1);
      end
      tail(3);
      run_stream($sformatf("rand%0d", it), nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have no parameters; oversampling SHALL be fixed at 16 ticks per bit.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 resetN  in  1  synchronous, active-low reset.
REQ-005 baudRateX16Tick  in  1  one-cycle strobe at 16x the baud rate.
REQ-006 controlReg  in  7  line control, bit by bit:
- [1:0]: word length, 0..3 = 5..8 bits.
- [2]: stop bits, 0 = 1 bit, 1 = 2 bits.
- [3]: parity enable.
- [4]: even parity select.
- [5]: stick parity.
- [6]: break control.
REQ-007 fifoEmpty  in  1  TX FIFO empty flag (first-word-fall-through FIFO).
REQ-008 fifoData  in  8  head-of-FIFO byte, valid whenever fifoEmpty=0.
REQ-009 fifoRe  out  1  one-cycle pop strobe to the TX FIFO.
REQ-010 uartTxLine  out  1  serial output, idle high.
REQ-011 txBusy  out  1  high while a frame is in progress.
REQ-012 txEmpty  out  1  high when txBusy=0 and fifoEmpty=1.

Function
REQ-013 States SHALL be IDLE, LOAD, START, DATA, PARITY and STOP.
REQ-014 Transitions SHALL be:
- IDLE->LOAD when fifoEmpty=0.
- LOAD->START after exactly one cycle.
- START->DATA after 16 ticks.
- DATA->PARITY after N data bits, when parity is enabled.
- DATA->STOP after N data bits, when parity is disabled.
- PARITY->STOP after 16 ticks.
- STOP->IDLE after 16 or 32 ticks.
REQ-015 In LOAD:
- fifoRe SHALL be high for exactly that one cycle.
- fifoData SHALL be latched into the shift register.
- controlReg[5:0] SHALL be latched.
- Mid-frame controlReg[5:0] changes SHALL take effect from the next frame only.
REQ-016 fifoRe SHALL never assert while fifoEmpty=1 and SHALL assert at most once per frame.
REQ-017 uartTxLine SHALL drive low from the first cycle of START.
REQ-018 Each bit period SHALL end on the 16th baudRateX16Tick counted in that state; the tick counter SHALL be 4 bits and wrap 15->0.
REQ-019 DATA SHALL shift LSB first, N = 5..8 bits; data bits above N-1 SHALL be ignored.
REQ-020 The parity bit SHALL be as follows:
- stick=0: XOR of the N data bits, inverted when controlReg[4]=0.
- stick=1: ~controlReg[4].
REQ-021 STOP SHALL drive uartTxLine high.
REQ-022 If fifoEmpty=0 at the STOP->IDLE transition, IDLE SHALL last exactly one cycle, so frames are back-to-back with no idle bit.
REQ-023 txBusy SHALL be high in every state except IDLE.
REQ-024 Break control:
- controlReg[6]=1 SHALL force uartTxLine low combinationally-registered within 1 cycle, in any state.
- The frame sequencing SHALL continue unaffected.
- IDLE SHALL not leave while break=1.
REQ-025 A baudRateX16Tick arriving in the LOAD cycle SHALL be ignored.
REQ-026 The output SHALL be glitch-free: uartTxLine SHALL be a register output.

Reset
REQ-027 While resetN=0 the block SHALL hold the following values, one cycle after sampling:
- state = IDLE.
- uartTxLine = 1.
- fifoRe = 0.
- txBusy = 0.
- txEmpty = fifoEmpty.
- tick and bit counters = 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no fifoRe SHALL be issued for the aborted byte.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, parity generation per REQ-020 SHALL be compiled in.
REQ-030 Without UART_TX_PARITY_EN:
- The PARITY state and parity logic SHALL be absent.
- controlReg[5:3] SHALL be ignored.
- Frames SHALL never carry a parity bit.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- The state enum.
- The controlReg bit-index constants.
- The word-length encoding.
- The ticks-per-bit constant (16).
REQ-032 One sub-module, uart_tx_parity_gen, SHALL compute parity from data, word length, even and stick; it SHALL be purely combinational.

Verification
REQ-033 The bench SHALL cover these scenarios, all with tick every cycle:
- 8N1, 0x55: line SHALL read 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level 16 cycles; 160 cycles from START to IDLE; fifoRe is one pulse.
- 7E1, 0x41: bits 1,0,0,0,0,0,1; the parity bit SHALL be 0.
- 5 bits, odd, 2 stop, 0x1F: the parity bit SHALL be 0; stop SHALL be high for 32 cycles.
- Two bytes queued, 8N1: the second start bit SHALL follow the first stop bit after exactly 2 cycles (IDLE+LOAD); there SHALL be 2 fifoRe pulses in total.
- Break asserted mid-DATA: uartTxLine SHALL be 0 within 1 cycle; txBusy SHALL drop after the frame's nominal end; no new LOAD while break=1.
- resetN low mid-DATA: next cycle uartTxLine=1, txBusy=0, no extra fifoRe.
